// File: rtl/adder_sum_capture.sv
// Sequencing stage around a delayed combinational adder: registers operands, waits a
// settle window, captures the sum. Optional build macro: SUM_CHECK_EN (sticky sum_err).
module adder_sum_capture #(
    parameter int W             = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     adder_a,
    output logic [W-1:0]     adder_b,
    input  logic [W:0]       adder_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_sum,
    output logic [CNT_W-1:0] txn_count,
    output logic             sum_err
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          capture;
    logic          drain;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign capture   = (state == SETTLE) && (cnt == '0);
    assign drain     = (state == HOLD) && out_ready;
    assign out_valid = (state == HOLD);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adder_a   <= '0;
            adder_b   <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            txn_count <= '0;
        end else begin
            // Operands only change on accept, keeping the adder inputs stable through HOLD.
            if (accept) begin
                adder_a <= in_a;
                adder_b <= in_b;
                cnt     <= CW'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) out_sum <= adder_sum;
            if (drain)   txn_count <= txn_count + CNT_W'(1);
        end
    end

`ifdef SUM_CHECK_EN
    logic [W:0] ref_sum;

    assign ref_sum = {1'b0, adder_a} + {1'b0, adder_b};

    always_ff @(posedge clk) begin
        if (!rst_n)                                sum_err <= 1'b0;
        else if (capture && adder_sum != ref_sum)  sum_err <= 1'b1;
    end
`else
    assign sum_err = 1'b0;
`endif

endmodule
